// File: rtl/stdcell_bist_ctrl.sv
// Exhaustive-pattern BIST sequencer for one combinational standard cell, with MISR response compaction.
// Optional golden-signature compare is built when STDCELL_BIST_CMP_EN is defined.
module stdcell_bist_ctrl #(
    parameter int              NIN    = 2,
    parameter int              SETTLE = 2,
    parameter int              NPASS  = 1,
    parameter int              SIGW   = 16,
    parameter logic [SIGW-1:0] POLY   = 16'h1021
) (
    input  logic            ck,
    input  logic            nrst,
    input  logic            start,
    output logic [NIN-1:0]  dut_i,
    input  logic            dut_nq,
    output logic            busy,
    output logic            done,
    output logic [SIGW-1:0] sig,
`ifdef STDCELL_BIST_CMP_EN
    input  logic [SIGW-1:0] golden,
    output logic            pass,
`endif
    output logic [1:0]      state_o
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int PW = $clog2(NPASS + 1);

    localparam logic [NIN-1:0] PAT_LAST    = '1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [PW-1:0]  PASS_LAST   = PW'(NPASS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q;
    logic [NIN-1:0]    pattern_q;
    logic [NIN-1:0]    dut_i_q;
    logic [SW-1:0]     settle_q;
    logic [PW-1:0]     pass_cnt_q;
    logic [SIGW-1:0]   sig_q;
    logic [SIGW-1:0]   sig_d;
    logic              busy_q;
    logic              done_q;
`ifdef STDCELL_BIST_CMP_EN
    logic              pass_q;
`endif

    // Galois MISR step: shift, fold in POLY on carry-out, then inject the cell response.
    always_comb begin
        sig_d    = (sig_q << 1) ^ (sig_q[SIGW-1] ? POLY : '0);
        sig_d[0] = sig_d[0] ^ dut_nq;
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            pattern_q  <= '0;
            dut_i_q    <= '0;
            settle_q   <= '0;
            pass_cnt_q <= '0;
            sig_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef STDCELL_BIST_CMP_EN
            pass_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_APPLY;
                        pattern_q  <= '0;
                        dut_i_q    <= '0;
                        settle_q   <= '0;
                        pass_cnt_q <= '0;
                        sig_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef STDCELL_BIST_CMP_EN
                        pass_q     <= 1'b0;
`endif
                    end
                end
                S_APPLY: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q  <= S_CAPTURE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    sig_q <= sig_d;
                    if (pattern_q == PAT_LAST && pass_cnt_q == PASS_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dut_i_q <= '0;
`ifdef STDCELL_BIST_CMP_EN
                        pass_q  <= (sig_d == golden);
`endif
                    end else begin
                        // Pattern counter wraps naturally on the last pattern of a pass.
                        state_q   <= S_APPLY;
                        pattern_q <= pattern_q + 1'b1;
                        dut_i_q   <= pattern_q + 1'b1;
                        if (pattern_q == PAT_LAST) begin
                            pass_cnt_q <= pass_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_i   = dut_i_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sig     = sig_q;
    assign state_o = state_q;
`ifdef STDCELL_BIST_CMP_EN
    assign pass    = pass_q;
`endif

endmodule

// File: tb/tb_stdcell_bist_ctrl.sv
// Directed bench for stdcell_bist_ctrl: NAND2 and stuck-at responses, NPASS=2, reset and restart sequencing.
// Compare tests run only when STDCELL_BIST_CMP_EN is defined.
module tb_stdcell_bist_ctrl;

    localparam int NIN    = 2;
    localparam int SETTLE = 2;

    logic        ck = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [1:0]  dut_i1, dut_i2;
    logic        nq1, nq2;
    logic        busy1, busy2, done1, done2;
    logic [15:0] sig1, sig2;
    logic [1:0]  state1, state2;
`ifdef STDCELL_BIST_CMP_EN
    logic [15:0] golden = 16'h0000;
    logic        pass1, pass2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // clock / reset block
    always #5 ck = ~ck;

    // Cell models: mode 0 = NAND2, 1 = stuck-at-1, 2 = stuck-at-0.
    assign nq1 = (mode == 2'd0) ? ~&dut_i1 : (mode == 2'd1);
    assign nq2 = ~&dut_i2;

    stdcell_bist_ctrl #(.NIN(NIN), .SETTLE(SETTLE), .NPASS(1)) u_dut (
        .ck(ck), .nrst(nrst), .start(start), .dut_i(dut_i1), .dut_nq(nq1),
        .busy(busy1), .done(done1), .sig(sig1),
`ifdef STDCELL_BIST_CMP_EN
        .golden(golden), .pass(pass1),
`endif
        .state_o(state1)
    );

    stdcell_bist_ctrl #(.NIN(NIN), .SETTLE(SETTLE), .NPASS(2)) u_dut2 (
        .ck(ck), .nrst(nrst), .start(start2), .dut_i(dut_i2), .dut_nq(nq2),
        .busy(busy2), .done(done2), .sig(sig2),
`ifdef STDCELL_BIST_CMP_EN
        .golden(golden), .pass(pass2),
`endif
        .state_o(state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // One run on u_dut from IDLE/DONE; hold keeps start high during the whole sweep.
    task automatic run_sweep(input bit hold, input logic [15:0] exp_sig, input string tag);
        int cyc;
        exp_q.delete();
        for (int p = 0; p < (1 << NIN); p++)
            for (int s = 0; s <= SETTLE; s++)
                exp_q.push_back(32'(p));
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        check({tag, "_start_done_low"}, 32'(done1), 32'd0);
        check({tag, "_start_sig_zero"}, 32'(sig1), 32'd0);
        cyc = 0;
        while (busy1 && cyc < 100) begin
            if (exp_q.size() == 0) check({tag, "_extra_busy"}, 32'd1, 32'd0);
            else check({tag, "_dut_i"}, 32'(dut_i1), exp_q.pop_front());
            cyc++;
            step();
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd12);
        check({tag, "_done"}, 32'(done1), 32'd1);
        check({tag, "_sig"}, 32'(sig1), 32'(exp_sig));
        check({tag, "_dut_i_idle"}, 32'(dut_i1), 32'd0);
        check({tag, "_state_done"}, 32'(state1), 32'd3);
    endtask

    initial begin
        int cyc;
        // reset
        nrst = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_sig", 32'(sig1), 32'd0);
        check("rst_dut_i", 32'(dut_i1), 32'd0);
        check("rst_state", 32'(state1), 32'd0);
        nrst = 1'b1;
        step();
        step();
        check("idle_stays", 32'(state1), 32'd0);

        mode = 2'd0;
        run_sweep(1'b0, 16'h000E, "nand");
        step();
        check("done_holds_sig", 32'(sig1), 32'h000E);
        check("done_holds_state", 32'(state1), 32'd3);
        run_sweep(1'b0, 16'h000E, "restart");

        mode = 2'd1;
        run_sweep(1'b0, 16'h000F, "tie1");
        mode = 2'd2;
        run_sweep(1'b0, 16'h0000, "tie0");
        mode = 2'd0;

        run_sweep(1'b1, 16'h000E, "hold");

        // reset in the middle of a run, at busy cycle 5
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy", 32'(busy1), 32'd1);
        check("mid_sig", 32'(sig1), 32'd1);
        check("mid_dut_i", 32'(dut_i1), 32'd1);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check("mrst_busy", 32'(busy1), 32'd0);
        check("mrst_done", 32'(done1), 32'd0);
        check("mrst_sig", 32'(sig1), 32'd0);
        check("mrst_dut_i", 32'(dut_i1), 32'd0);
        check("mrst_state", 32'(state1), 32'd0);
        step();
        check("mrst_idle", 32'(state1), 32'd0);
        run_sweep(1'b0, 16'h000E, "after_rst");

        // reset and start together
        nrst = 1'b0;
        start = 1'b1;
        step();
        check("rst_wins_busy", 32'(busy1), 32'd0);
        check("rst_wins_state", 32'(state1), 32'd0);
        nrst = 1'b1;
        start = 1'b0;
        step();
        check("rst_wins_idle", 32'(state1), 32'd0);

        // two exhaustive passes
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 200) begin
            cyc++;
            step();
        end
        check("np2_busy_cycles", 32'(cyc), 32'd24);
        check("np2_done", 32'(done2), 32'd1);
        check("np2_sig", 32'(sig2), 32'h00EE);
        check("np2_sig_differs", 32'(sig2 != 16'h000E), 32'd1);

`ifdef STDCELL_BIST_CMP_EN
        golden = 16'h000E;
        run_sweep(1'b0, 16'h000E, "cmp_good");
        check("cmp_pass_good", 32'(pass1), 32'd1);
        golden = 16'h000F;
        run_sweep(1'b0, 16'h000E, "cmp_bad");
        check("cmp_pass_bad", 32'(pass1), 32'd0);
        golden = 16'h000E;
        run_sweep(1'b0, 16'h000E, "cmp_again");
        check("cmp_pass_again", 32'(pass1), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("cmp_pass_cleared", 32'(pass1), 32'd0);
        cyc = 0;
        while (busy1 && cyc < 100) begin
            cyc++;
            step();
        end
        check("cmp_pass_final", 32'(pass1), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
